wb_load_sequencer: RTL and testbench
====================================

Name: wb_load_sequencer

Overview:
- Controls the register-file write port of the RV32I core when data memory has variable latency.
- ALU, jump (PC+4) and don't-care writebacks complete in the same cycle, as in the single-cycle core.
- Loads (reg_write_mode = 1) stall the core, issue a memory read, wait for mem_ready, then perform one registered writeback of the captured load data.
- Sits between decode/execute and the register file, and drives the PC-hold/stall line.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before a load is abandoned (only used with WB_TIMEOUT_EN).
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  the current instruction is executing this cycle.
- reg_write_en  in  1  the instruction writes rd.
- reg_write_mode  in  2  writeback source: 0 = ALU, 1 = load data, 2 = PC+4, 3 = ALU.
- rd  in  5  destination register.
- ALU_result  in  32  ALU output.
- PC_plus_4  in  32  return address for jumps.
- read_data  in  32  data-memory read data, valid when mem_ready = 1.
- mem_ready  in  1  memory response strobe.
- mem_rd_req  out  1  memory read request, held high until mem_ready.
- stall  out  1  freezes PC and the pipeline inputs while high.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- load_err  out  1  one-cycle pulse when a load times out (WB_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- States: IDLE, WAIT, WB. Reset (rst_n = 0, asynchronous) forces IDLE, clears the wait counter, latched rd and latched data, and drives every output to 0.
- Reset mid-load aborts the load: no writeback, mem_rd_req drops immediately.
- IDLE, non-load (instr_valid = 1, mode != 1):
  - Combinational writeback in the same cycle.
  - rf_we = reg_write_en && (rd != 0).
  - rf_waddr = rd.
  - rf_wdata = PC_plus_4 if mode = 2, else ALU_result (modes 0 and 3).
  - stall = 0.
- IDLE, load (instr_valid = 1, mode = 1, reg_write_en = 1):
  - Combinationally: stall = 1, mem_rd_req = 1, rf_we = 0.
  - On the clock edge: latch rd, clear the counter, go to WAIT.
  - A load with reg_write_en = 0 is treated as a non-load with no write.
- IDLE, instr_valid = 0: all outputs 0.
- WAIT:
  - stall = 1, mem_rd_req = 1, rf_we = 0. instr_valid, mode and rd are ignored.
  - On mem_ready = 1: capture read_data, go to WB.
  - mem_ready in the same cycle as entry into WAIT is the IDLE-load cycle itself; a response there is also accepted (0-wait memory). Total latency is then 1 stall cycle + WB.
- WB:
  - Registered outputs: rf_we = (latched rd != 0), rf_waddr = latched rd, rf_wdata = captured data.
  - stall = 0 so the load retires and the PC advances on this edge.
  - Return to IDLE next cycle.
  - The instruction presented during WB is the load itself (PC still held at the WB edge). Its instr_valid is ignored, so there is no double issue.
- Load latency: stall cycles = 1 + memory wait cycles; writeback occurs in the cycle after mem_ready.
- mem_ready while in IDLE or WB is ignored.
- Writes to x0 are always suppressed; the sequencer still sequences the memory access.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined: the counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES with no mem_ready:
  - load_err pulses for one cycle;
  - mem_rd_req drops;
  - go to IDLE with no register write and stall = 0 in that cycle.
  - mem_ready arriving in the same cycle as the timeout takes priority; the load completes normally.
- Undefined: WAIT persists indefinitely, the counter is not implemented, and load_err is constant 0.

Test Plan:
- ADD-type (mode 0, rd = 5, ALU_result = 0x00000010) → same cycle: rf_we = 1, waddr = 5, wdata = 0x10, stall = 0.
- JAL (mode 2, rd = 1, PC_plus_4 = 0x00000104) → wdata = 0x104. Same with rd = 0 → rf_we = 0.
- Load rd = 7, mem_ready after 3 WAIT cycles with read_data = 0xDEADBEEF:
  - stall high for 4 cycles;
  - mem_rd_req high until the ready cycle;
  - next cycle: rf_we = 1, waddr = 7, wdata = 0xDEADBEEF, stall = 0.
- Load with mem_ready in the issue cycle → exactly 1 stall cycle, then the WB write. Back-to-back loads with rd = 3 then rd = 4 → two separate writes, no overlap.
- Reset asserted in WAIT → outputs 0 asynchronously, no write ever occurs, IDLE after release.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, mem_ready never arrives → load_err pulses after 16 WAIT cycles, rf_we stays 0, stall releases. Also test mem_ready on cycle 16 → normal writeback, no load_err.

Source files
------------

// File: rtl/wb_load_sequencer.sv
// wb_load_sequencer: register-file writeback controller for an RV32I core
// with a variable-latency data memory. ALU and jump writebacks complete in
// the issue cycle. A load stalls the core, holds a memory read request
// until mem_ready, then retires through one registered writeback cycle.
// Optional feature macro: WB_TIMEOUT_EN abandons a load after
// TIMEOUT_CYCLES wait cycles without a response and pulses load_err.
module wb_load_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        reg_write_en,
  input  logic [1:0]  reg_write_mode,
  input  logic [4:0]  rd,
  input  logic [31:0] ALU_result,
  input  logic [31:0] PC_plus_4,
  input  logic [31:0] read_data,
  input  logic        mem_ready,
  output logic        mem_rd_req,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        load_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // The wait counter must be able to hold TIMEOUT_CYCLES.
  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("wb_load_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        is_load;

`ifdef WB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic             err_q;
  assign err_q = 1'b0;
`endif

  assign is_load = instr_valid && (reg_write_mode == 2'd1) && reg_write_en;

  // Next-state, load-register latch and capture of the returned data.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    data_d  = data_q;
`ifdef WB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // The cycle after an abandoned load is that load retiring, so a
        // load still presented on the inputs must not be re-issued.
        if (is_load && !err_q) begin
          rd_d = rd;
`ifdef WB_TIMEOUT_EN
          cnt_d = '0;
`endif
          // A 0-wait memory answers in the issue cycle itself.
          if (mem_ready) begin
            data_d  = read_data;
            state_d = S_WB;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A response always wins over a timeout in the same cycle.
        if (mem_ready) begin
          data_d  = read_data;
          state_d = S_WB;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched load context, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      data_q  <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    mem_rd_req = 1'b0;
    stall      = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    load_err   = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (err_q) begin
            load_err = 1'b1;
          end else if (instr_valid) begin
            if (is_load) begin
              mem_rd_req = 1'b1;
              stall      = 1'b1;
            end else begin
              rf_we    = reg_write_en && (rd != 5'd0);
              rf_waddr = rd;
              rf_wdata = (reg_write_mode == 2'd2) ? PC_plus_4 : ALU_result;
            end
          end
        end
        S_WAIT: begin
          mem_rd_req = 1'b1;
          stall      = 1'b1;
        end
        S_WB: begin
          rf_we    = (rd_q != 5'd0);
          rf_waddr = rd_q;
          rf_wdata = data_q;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_load_sequencer.sv
// Bench for wb_load_sequencer: a transaction-level model checked every
// cycle, plus directed vectors with literal expectations.
module tb_wb_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        reg_write_en = 1'b0;
  logic [1:0]  reg_write_mode = 2'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] ALU_result = 32'd0;
  logic [31:0] PC_plus_4 = 32'd0;
  logic [31:0] read_data = 32'd0;
  logic        mem_ready = 1'b0;
  logic        mem_rd_req, stall, rf_we, load_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad   = 0;

`ifdef WB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 0;
`endif

  always #5 clk = ~clk;

  wb_load_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
    .reg_write_en(reg_write_en), .reg_write_mode(reg_write_mode), .rd(rd),
    .ALU_result(ALU_result), .PC_plus_4(PC_plus_4), .read_data(read_data),
    .mem_ready(mem_ready), .mem_rd_req(mem_rd_req), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_err(load_err)
  );

  // Model: one outstanding load at most; flags say what the current cycle is.
  bit          m_busy, m_wb, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_waits;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_wb <= 0; m_err <= 0; m_rd <= '0; m_data <= '0; m_waits <= 0;
    end else if (m_wb) begin
      m_wb <= 0;
    end else if (m_err) begin
      m_err <= 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_data <= read_data; m_busy <= 0; m_wb <= 1;
      end else begin
        if (TO != 0 && m_waits + 1 == TO) begin
          m_busy <= 0; m_err <= 1;
        end
        m_waits <= m_waits + 1;
      end
    end else if (instr_valid && reg_write_mode == 2'd1 && reg_write_en) begin
      m_rd <= rd; m_waits <= 0;
      if (mem_ready) begin
        m_data <= read_data; m_wb <= 1;
      end else begin
        m_busy <= 1;
      end
    end
  end

  // {req, stall, we, addr, data, err}
  function automatic logic [40:0] model_out();
    logic e_req, e_st, e_we, e_err;
    logic [4:0] e_a;
    logic [31:0] e_d;
    e_req = 0; e_st = 0; e_we = 0; e_err = 0; e_a = '0; e_d = '0;
    if (!rst_n) begin
      e_req = 0;
    end else if (m_wb) begin
      e_we = (m_rd != 0); e_a = m_rd; e_d = m_data;
    end else if (m_err) begin
      e_err = 1;
    end else if (m_busy) begin
      e_req = 1; e_st = 1;
    end else if (instr_valid) begin
      if (reg_write_mode == 2'd1 && reg_write_en) begin
        e_req = 1; e_st = 1;
      end else begin
        e_we = reg_write_en && (rd != 0);
        e_a  = rd;
        e_d  = (reg_write_mode == 2'd2) ? PC_plus_4 : ALU_result;
      end
    end
    return {e_req, e_st, e_we, e_a, e_d, e_err};
  endfunction

  always @(negedge clk) begin
    logic [40:0] exp_v, act_v;
    exp_v = model_out();
    act_v = {mem_rd_req, stall, rf_we, rf_waddr, rf_wdata, load_err};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model_cycle t=%0t got req=%b stall=%b we=%b addr=%0d data=%h err=%b want req=%b stall=%b we=%b addr=%0d data=%h err=%b",
               $time, act_v[40], act_v[39], act_v[38], act_v[37:33], act_v[32:1], act_v[0],
               exp_v[40], exp_v[39], exp_v[38], exp_v[37:33], exp_v[32:1], exp_v[0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input bit we, input logic [1:0] m, input logic [4:0] r);
    instr_valid = v; reg_write_en = we; reg_write_mode = m; rd = r;
  endtask

  initial begin
    int n;
    // Reset: outputs low even with a writing instruction on the inputs.
    set_in(1, 1, 2'd0, 5'd5); ALU_result = 32'h10;
    #2;
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD rd=5
    @(negedge clk);
    chk("add_we", {31'd0, rf_we}, 32'd1);
    chk("add_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("add_wdata", rf_wdata, 32'h10);
    chk("add_stall", {31'd0, stall}, 32'd0);
    cyc();

    // JAL rd=1, then rd=0
    set_in(1, 1, 2'd2, 5'd1); PC_plus_4 = 32'h104; ALU_result = 32'h999;
    @(negedge clk);
    chk("jal_wdata", rf_wdata, 32'h104);
    chk("jal_we", {31'd0, rf_we}, 32'd1);
    cyc();
    rd = 5'd0;
    @(negedge clk);
    chk("jal_x0_we", {31'd0, rf_we}, 32'd0);
    cyc();

    // mode 3 selects ALU; load with reg_write_en=0 acts as a no-write op
    set_in(1, 1, 2'd3, 5'd9); ALU_result = 32'h55;
    @(negedge clk);
    chk("mode3_wdata", rf_wdata, 32'h55);
    cyc();
    set_in(1, 0, 2'd1, 5'd6); ALU_result = 32'h77;
    @(negedge clk);
    chk("load_nowe_stall", {31'd0, stall}, 32'd0);
    chk("load_nowe_we", {31'd0, rf_we}, 32'd0);
    cyc();

    // mem_ready in IDLE is ignored
    set_in(0, 0, 2'd0, 5'd0); mem_ready = 1; read_data = 32'h12345678;
    cyc();
    mem_ready = 0;

    // Load rd=7, response after 3 wait cycles
    set_in(1, 1, 2'd1, 5'd7); read_data = 32'h0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) rd = 5'd12;
      if (i == 3) begin mem_ready = 1; read_data = 32'hDEADBEEF; end
      @(negedge clk);
      if (stall) n++;
      chk("load7_req", {31'd0, mem_rd_req}, 32'd1);
      cyc();
    end
    mem_ready = 0; read_data = 32'h0; rd = 5'd7;
    @(negedge clk);
    chk("load7_stall_cycles", n, 32'd4);
    chk("load7_we", {31'd0, rf_we}, 32'd1);
    chk("load7_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("load7_wdata", rf_wdata, 32'hDEADBEEF);
    chk("load7_wb_stall", {31'd0, stall}, 32'd0);
    chk("load7_wb_req", {31'd0, mem_rd_req}, 32'd0);
    cyc();

    // Back-to-back: 0-wait load rd=3, then load rd=4 with one wait cycle
    set_in(1, 1, 2'd1, 5'd3); mem_ready = 1; read_data = 32'h11111111;
    @(negedge clk);
    chk("ld3_issue_stall", {31'd0, stall}, 32'd1);
    cyc();
    mem_ready = 0; read_data = 32'h0;
    @(negedge clk);
    chk("ld3_wb_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("ld3_wb_wdata", rf_wdata, 32'h11111111);
    chk("ld3_wb_stall", {31'd0, stall}, 32'd0);
    cyc();
    rd = 5'd4;
    @(negedge clk);
    chk("ld4_issue_we", {31'd0, rf_we}, 32'd0);
    cyc();
    mem_ready = 1; read_data = 32'h22222222;
    cyc();
    mem_ready = 0; read_data = 32'h0;
    @(negedge clk);
    chk("ld4_wb_waddr", {27'd0, rf_waddr}, 32'd4);
    chk("ld4_wb_wdata", rf_wdata, 32'h22222222);
    cyc();

    // 0-wait load to x0: sequenced but never written
    set_in(1, 1, 2'd1, 5'd0); mem_ready = 1; read_data = 32'h33333333;
    cyc();
    mem_ready = 0;
    @(negedge clk);
    chk("ldx0_we", {31'd0, rf_we}, 32'd0);
    set_in(0, 0, 2'd0, 5'd0);
    cyc();

    // Reset in WAIT aborts the load
    set_in(1, 1, 2'd1, 5'd8);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst_wait_stall", {31'd0, stall}, 32'd0);
    set_in(0, 0, 2'd0, 5'd0); mem_ready = 1; read_data = 32'h44444444;
    cyc();
    cyc();
    rst_n = 1'b1;
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_after_we", {31'd0, rf_we}, 32'd0);
      cyc();
    end

`ifdef WB_TIMEOUT_EN
    // No response: 1 issue + 16 wait cycles stalled, then the error cycle
    set_in(1, 1, 2'd1, 5'd10);
    n = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (stall) n++;
      cyc();
    end
    @(negedge clk);
    chk("to_stall_cycles", n, 32'd17);
    chk("to_err", {31'd0, load_err}, 32'd1);
    chk("to_err_stall", {31'd0, stall}, 32'd0);
    chk("to_err_req", {31'd0, mem_rd_req}, 32'd0);
    chk("to_err_we", {31'd0, rf_we}, 32'd0);
    cyc();
    set_in(0, 0, 2'd0, 5'd0);
    @(negedge clk);
    chk("to_err_pulse", {31'd0, load_err}, 32'd0);
    cyc();

    // Response on the 16th wait cycle completes normally
    set_in(1, 1, 2'd1, 5'd11);
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin mem_ready = 1; read_data = 32'hCAFEF00D; end
      cyc();
    end
    mem_ready = 0;
    @(negedge clk);
    chk("to_late_we", {31'd0, rf_we}, 32'd1);
    chk("to_late_wdata", rf_wdata, 32'hCAFEF00D);
    chk("to_late_err", {31'd0, load_err}, 32'd0);
    cyc();
    set_in(0, 0, 2'd0, 5'd0);
`endif

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
